// File: rtl/time_setter.sv
// Operator-side editor for the countdown time register: button pulses edit a
// BCD HH:MM:SS value digit by digit and a legal value is committed with a write strobe.
module time_setter #(
  parameter int MAX_HOUR   = 23,
  parameter bit ALLOW_ZERO = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btnEnter,
  input  logic       btnNext,
  input  logic       btnUp,
  input  logic       btnDown,
  input  logic       busy,
  output logic [3:0] setHour10,
  output logic [3:0] setHour1,
  output logic [3:0] setMinute10,
  output logic [3:0] setMinute1,
  output logic [3:0] setSecond10,
  output logic [3:0] setSecond1,
  output logic       write,
  output logic       editing,
  output logic [2:0] cursor,
  output logic       error
);

  localparam logic [3:0] H10_MAX = 4'(MAX_HOUR / 10);
  localparam logic [3:0] H1_TOP  = 4'(MAX_HOUR % 10);

  typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;

  state_t     state;
  logic [3:0] dig [6];
  logic [3:0] cur_val;
  logic [3:0] cur_max;
  logic [3:0] step_val;
  logic       clamp_h1;
  logic       all_zero;

  // Hour1 range shrinks when Hour10 sits at its top value.
  function automatic logic [3:0] digit_max(input logic [2:0] idx, input logic [3:0] h10);
    case (idx)
      3'd0:       digit_max = H10_MAX;
      3'd1:       digit_max = (h10 >= H10_MAX) ? H1_TOP : 4'd9;
      3'd2, 3'd4: digit_max = 4'd5;
      default:    digit_max = 4'd9;
    endcase
  endfunction

  always_comb begin
    cur_val = 4'd0;
    case (cursor)
      3'd0:    cur_val = dig[0];
      3'd1:    cur_val = dig[1];
      3'd2:    cur_val = dig[2];
      3'd3:    cur_val = dig[3];
      3'd4:    cur_val = dig[4];
      3'd5:    cur_val = dig[5];
      default: cur_val = 4'd0;
    endcase
    cur_max = digit_max(cursor, dig[0]);
    if (btnUp)
      step_val = (cur_val >= cur_max) ? 4'd0 : cur_val + 4'd1;
    else
      step_val = (cur_val == 4'd0 || cur_val > cur_max) ? cur_max : cur_val - 4'd1;
    // A new Hour10 at its top value can push HH past MAX_HOUR.
    clamp_h1 = (cursor == 3'd0) && (step_val == H10_MAX) && (dig[1] > H1_TOP);
    all_zero = (dig[0] == 4'd0) && (dig[1] == 4'd0) && (dig[2] == 4'd0) &&
               (dig[3] == 4'd0) && (dig[4] == 4'd0) && (dig[5] == 4'd0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      write   <= 1'b0;
      editing <= 1'b0;
      cursor  <= 3'd0;
      error   <= 1'b0;
      for (int i = 0; i < 6; i++) dig[i] <= 4'd0;
    end else begin
      write <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (btnEnter && !busy) begin
            state   <= EDIT;
            editing <= 1'b1;
            cursor  <= 3'd0;
          end
        end
        EDIT: begin
          if (busy) begin
            state   <= IDLE;
            editing <= 1'b0;
            cursor  <= 3'd0;
          end else if (btnEnter) begin
            if (!ALLOW_ZERO && all_zero) begin
              error <= 1'b1;
            end else begin
              state   <= COMMIT;
              write   <= 1'b1;
              editing <= 1'b0;
              cursor  <= 3'd0;
            end
          end else if (btnNext) begin
            cursor <= (cursor >= 3'd5) ? 3'd0 : cursor + 3'd1;
          end else if (btnUp || btnDown) begin
            for (int i = 0; i < 6; i++)
              if (cursor == 3'(i)) dig[i] <= step_val;
            if (clamp_h1) dig[1] <= H1_TOP;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign setHour10   = dig[0];
  assign setHour1    = dig[1];
  assign setMinute10 = dig[2];
  assign setMinute1  = dig[3];
  assign setSecond10 = dig[4];
  assign setSecond1  = dig[5];

endmodule

// File: tb/tb_time_setter.sv
// Bench for time_setter: directed scenarios plus random button traffic,
// all compared against an arithmetic reference model of the editor.
module tb_time_setter;

  localparam int MAX_HOUR   = 23;
  localparam bit ALLOW_ZERO = 1'b0;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       btnEnter = 1'b0, btnNext = 1'b0, btnUp = 1'b0, btnDown = 1'b0, busy = 1'b0;
  logic [3:0] setHour10, setHour1, setMinute10, setMinute1, setSecond10, setSecond1;
  logic       write, editing, error;
  logic [2:0] cursor;

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0=idle 1=edit 2=commit
  int m_mode;
  int m_dig[6];
  int m_cur;
  int m_write, m_error;

  time_setter #(.MAX_HOUR(MAX_HOUR), .ALLOW_ZERO(ALLOW_ZERO)) dut (
    .clock(clock), .reset(reset),
    .btnEnter(btnEnter), .btnNext(btnNext), .btnUp(btnUp), .btnDown(btnDown), .busy(busy),
    .setHour10(setHour10), .setHour1(setHour1), .setMinute10(setMinute10),
    .setMinute1(setMinute1), .setSecond10(setSecond10), .setSecond1(setSecond1),
    .write(write), .editing(editing), .cursor(cursor), .error(error)
  );

  always #5 clock = ~clock;

  function automatic int dmax(int i);
    case (i)
      0:       return MAX_HOUR / 10;
      1:       return (m_dig[0] == MAX_HOUR / 10) ? MAX_HOUR % 10 : 9;
      2, 4:    return 5;
      default: return 9;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cur = 0; m_write = 0; m_error = 0;
    for (int i = 0; i < 6; i++) m_dig[i] = 0;
  endtask

  task automatic model_update(input bit e, input bit n, input bit u, input bit d, input bit b);
    int mx, secs;
    m_write = 0; m_error = 0;
    secs = (m_dig[0]*10 + m_dig[1])*3600 + (m_dig[2]*10 + m_dig[3])*60 + m_dig[4]*10 + m_dig[5];
    case (m_mode)
      0: if (e && !b) begin m_mode = 1; m_cur = 0; end
      1: begin
        if (b) begin m_mode = 0; m_cur = 0; end
        else if (e) begin
          if (!ALLOW_ZERO && secs == 0) m_error = 1;
          else begin m_mode = 2; m_write = 1; m_cur = 0; end
        end
        else if (n) m_cur = (m_cur + 1) % 6;
        else if (u || d) begin
          mx = dmax(m_cur);
          m_dig[m_cur] = u ? (m_dig[m_cur] + 1) % (mx + 1) : (m_dig[m_cur] + mx) % (mx + 1);
          if (m_dig[0]*10 + m_dig[1] > MAX_HOUR) m_dig[1] = MAX_HOUR % 10;
        end
      end
      default: m_mode = 0;
    endcase
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("hour10", {4'd0, setHour10}, 8'(m_dig[0]));
    chk("hour1", {4'd0, setHour1}, 8'(m_dig[1]));
    chk("minute10", {4'd0, setMinute10}, 8'(m_dig[2]));
    chk("minute1", {4'd0, setMinute1}, 8'(m_dig[3]));
    chk("second10", {4'd0, setSecond10}, 8'(m_dig[4]));
    chk("second1", {4'd0, setSecond1}, 8'(m_dig[5]));
    chk("write", {7'd0, write}, 8'(m_write));
    chk("editing", {7'd0, editing}, 8'(m_mode == 1));
    chk("cursor", {5'd0, cursor}, 8'(m_cur));
    chk("error", {7'd0, error}, 8'(m_error));
  endtask

  // One clock: drive pulses, advance model at the edge, check 1 time unit later.
  task automatic cyc(input bit e, input bit n, input bit u, input bit d, input bit b);
    btnEnter = e; btnNext = n; btnUp = u; btnDown = d; busy = b;
    @(posedge clock);
    model_update(e, n, u, d, b);
    #1;
    check_all();
    btnEnter = 0; btnNext = 0; btnUp = 0; btnDown = 0;
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1 model_reset();
    check_all();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    busy = 1'b0;
  endtask

  initial begin
    model_reset();
    #3 check_all();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;

    // Edit to 12:34:56, then reset mid-edit
    cyc(1,0,0,0,0);
    cyc(0,0,1,0,0);
    for (int k = 1; k < 6; k++) begin
      cyc(0,1,0,0,0);
      for (int j = 0; j <= k; j++) cyc(0,0,1,0,0);
    end
    chk("pre_reset_s1", {4'd0, setSecond1}, 8'd6);
    do_reset();
    chk("reset_h10", {4'd0, setHour10}, 8'd0);

    // Enter, Up, Next, Up x3, Enter -> 13:00:00 committed
    cyc(1,0,0,0,0);
    cyc(0,0,1,0,0);
    cyc(0,1,0,0,0);
    for (int j = 0; j < 3; j++) cyc(0,0,1,0,0);
    cyc(1,0,0,0,0);
    chk("commit_write", {7'd0, write}, 8'd1);
    chk("commit_h1", {4'd0, setHour1}, 8'd3);
    chk("commit_edit", {7'd0, editing}, 8'd0);
    cyc(0,0,0,0,0);
    chk("commit_done", {7'd0, write}, 8'd0);
    cyc(0,0,1,0,0);   // Up in IDLE ignored

    // Minute10 wrap both ways, Second1 down from 0
    cyc(1,0,0,0,0);
    cyc(0,1,0,0,0);
    cyc(0,1,0,0,0);
    cyc(0,0,0,1,0);
    chk("m10_down_wrap", {4'd0, setMinute10}, 8'd5);
    cyc(0,0,1,0,0);
    chk("m10_up_wrap", {4'd0, setMinute10}, 8'd0);
    cyc(0,0,0,1,0);
    for (int j = 0; j < 3; j++) cyc(0,1,0,0,0);
    cyc(0,0,0,1,0);
    chk("s1_down_wrap", {4'd0, setSecond1}, 8'd9);

    // Abort by busy, then Hour clamp 19 -> 23
    cyc(0,0,1,0,1);
    chk("abort_edit", {7'd0, editing}, 8'd0);
    cyc(1,0,0,0,1);   // Enter while busy ignored
    cyc(1,0,0,0,0);
    cyc(0,1,0,0,0);
    for (int j = 0; j < 6; j++) cyc(0,0,1,0,0);
    for (int j = 0; j < 5; j++) cyc(0,1,0,0,0);
    cyc(0,0,1,0,0);
    chk("clamp_h10", {4'd0, setHour10}, 8'd2);
    chk("clamp_h1", {4'd0, setHour1}, 8'd3);
    cyc(0,1,0,0,0);
    cyc(0,0,1,0,0);
    chk("h1_top_wrap", {4'd0, setHour1}, 8'd0);
    cyc(0,0,0,1,0);
    chk("h1_down_top", {4'd0, setHour1}, 8'd3);

    // Zero commit rejected
    do_reset();
    cyc(1,0,0,0,0);
    cyc(1,0,0,0,0);
    chk("zero_error", {7'd0, error}, 8'd1);
    chk("zero_nowrite", {7'd0, write}, 8'd0);
    cyc(0,0,0,0,0);
    chk("zero_error_pulse", {7'd0, error}, 8'd0);

    // Enter + Up together commits without changing the digit
    cyc(0,0,1,0,0);
    cyc(1,0,1,0,0);
    chk("prio_write", {7'd0, write}, 8'd1);
    chk("prio_h10", {4'd0, setHour10}, 8'd1);
    cyc(1,0,0,0,0);   // Enter in COMMIT ignored
    cyc(0,0,0,0,0);

    // Random traffic
    for (int t = 0; t < 800; t++) begin
      cyc($urandom_range(0,7) == 0, $urandom_range(0,3) == 0, $urandom_range(0,2) == 0,
          $urandom_range(0,2) == 0, $urandom_range(0,19) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
